// File: rtl/pio_out_pkg.sv
// Shared constants for the Avalon output PIO: register word addresses and bus widths.
package pio_out_pkg;

    localparam int ADDR_W = 3;
    localparam int MAX_W  = 32;

    localparam logic [ADDR_W-1:0] ADDR_DATA       = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_BLINK_MASK = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_SET        = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_CLEAR      = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_TOGGLE     = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_PERIOD     = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_STATUS     = 3'd6;
    localparam logic [ADDR_W-1:0] ADDR_RSVD       = 3'd7;

    function automatic logic bus_write_en(input logic chipselect, input logic write_n);
        return chipselect & ~write_n;
    endfunction

endpackage

// File: rtl/avalon_pio_out_if.sv
// Avalon-MM slave bus bundle for the output PIO (zero-wait-state, combinational read).
interface avalon_pio_out_if;
    import pio_out_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [MAX_W-1:0]  writedata;
    logic [MAX_W-1:0]  readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/pio_blink_timer.sv
// Blink half-period down-counter and phase bit; a load restarts the half-period with phase=1.
module pio_blink_timer #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [PERIOD_W-1:0] period,
    input  logic                load,
    output logic                phase
);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                phase_q, phase_d;

    // Next-state: load wins over terminal count; PERIOD=0 parks the engine.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (load) begin
            cnt_d   = period;
            phase_d = 1'b1;
        end else if (period == {PERIOD_W{1'b0}}) begin
            cnt_d   = {PERIOD_W{1'b0}};
            phase_d = 1'b1;
        end else if (cnt_q == {PERIOD_W{1'b0}}) begin
            cnt_d   = period;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q - PERIOD_W'(1'b1);
            phase_d = phase_q;
        end
    end

    // Counter and phase state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= {PERIOD_W{1'b0}};
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/avalon_pio_out.sv
// Parametrised Avalon-MM output PIO with atomic SET/CLEAR/TOGGLE.
// Build option PIO_BLINK_EN adds BLINK_MASK, PERIOD and STATUS with a hardware blink engine.
module avalon_pio_out
    import pio_out_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}},
    parameter int                PERIOD_W  = 24
) (
    input  logic                  clk,
    input  logic                  reset_n,
    avalon_pio_out_if.slave       bus,
    output logic [DATA_W-1:0]     out_port
);

    logic              wr_en_s;
    logic [DATA_W-1:0] wd_s;
    logic [DATA_W-1:0] data_q, data_d;
    logic [MAX_W-1:0]  rd_s;
    logic              phase_s;
    logic              unused_wd_s;

    assign wr_en_s     = bus_write_en(bus.chipselect, bus.write_n);
    assign wd_s        = bus.writedata[DATA_W-1:0];
    assign unused_wd_s = &{1'b0, bus.writedata};

    // DATA next-state from direct and atomic bit writes.
    always_comb begin
        data_d = data_q;
        if (wr_en_s) begin
            case (bus.address)
                ADDR_DATA:   data_d = wd_s;
                ADDR_SET:    data_d = data_q | wd_s;
                ADDR_CLEAR:  data_d = data_q & ~wd_s;
                ADDR_TOGGLE: data_d = data_q ^ wd_s;
                default:     data_d = data_q;
            endcase
        end else begin
            data_d = data_q;
        end
    end

    // DATA register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= RESET_VAL;
        end else begin
            data_q <= data_d;
        end
    end

`ifdef PIO_BLINK_EN
    logic [DATA_W-1:0]   mask_q, mask_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                load_s;

    // BLINK_MASK and PERIOD next-state; a PERIOD write also restarts the timer.
    always_comb begin
        mask_d   = mask_q;
        period_d = period_q;
        load_s   = 1'b0;
        if (wr_en_s && bus.address == ADDR_BLINK_MASK) begin
            mask_d = wd_s;
        end else begin
            mask_d = mask_q;
        end
        if (wr_en_s && bus.address == ADDR_PERIOD) begin
            period_d = bus.writedata[PERIOD_W-1:0];
            load_s   = 1'b1;
        end else begin
            period_d = period_q;
            load_s   = 1'b0;
        end
    end

    // Blink configuration registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q   <= {DATA_W{1'b0}};
            period_q <= {PERIOD_W{1'b0}};
        end else begin
            mask_q   <= mask_d;
            period_q <= period_d;
        end
    end

    // The timer sees the incoming PERIOD on the load edge, so cnt picks up the new value.
    pio_blink_timer #(.PERIOD_W(PERIOD_W)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .period  (period_d),
        .load    (load_s),
        .phase   (phase_s)
    );

    assign out_port = data_q & (~mask_q | {DATA_W{phase_s}});
`else
    assign phase_s  = 1'b0;
    assign out_port = data_q;
`endif

    // Zero-wait-state read mux, zero-extended; write-only and absent registers read 0.
    always_comb begin
        rd_s = {MAX_W{1'b0}};
        case (bus.address)
            ADDR_DATA:       rd_s[DATA_W-1:0]   = data_q;
`ifdef PIO_BLINK_EN
            ADDR_BLINK_MASK: rd_s[DATA_W-1:0]   = mask_q;
            ADDR_PERIOD:     rd_s[PERIOD_W-1:0] = period_q;
            ADDR_STATUS:     rd_s[0]            = phase_s;
`endif
            default:         rd_s = {MAX_W{1'b0}};
        endcase
    end

    assign bus.readdata = rd_s;

endmodule
